address_generation_unit_mc: RTL and testbench
=============================================

// Module: address_generation_unit_mc
// PURPOSE
//   Multi-channel successor of the core address generation unit. It holds NCH independent
//   pointer channels, each with its own base, length, signed step and mode (linear or circular).
//   The block serves one address request per cycle from the load/store/DMA sequencer, through a
//   registered output stage that supports backpressure.
// PARAMETERS
//   ADDR_W  16  address and pointer width
//   NCH      4  number of pointer channels (power of 2, >=2)
//   STEP_W   8  width of the signed step register (STEP_W <= ADDR_W)
// PORTS
//   clk          in   1               system clock, rising edge
//   s_reset      in   1               synchronous active-high reset
//   cfg_we       in   1               configuration write strobe
//   cfg_ch       in   $clog2(NCH)     channel being configured
//   cfg_sel      in   2               0=base (also loads ptr) 1=length 2=step 3=mode(bit0: 0 lin, 1 circ)
//   cfg_wdata    in   ADDR_W          write data (step uses [STEP_W-1:0], mode uses [0])
//   req_valid    in   1               address request
//   req_ready    out  1               request accepted when req_valid && req_ready
//   req_ch       in   $clog2(NCH)     channel addressed
//   req_op       in   2               00 peek, 01 post-modify, 10 pre-modify, 11 reload ptr=base
//   addr_valid   out  1               output address valid
//   addr_ready   in   1               downstream accepts output
//   addr         out  ADDR_W          generated address
//   addr_ch      out  $clog2(NCH)     channel that produced addr
//   addr_wrap    out  1               pointer update wrapped (circular or 2^ADDR_W overflow)
// BEHAVIOUR
//   Reset (s_reset=1 at clk edge): all ptr/base=0, len=0, step=+1, mode=linear; addr_valid=0,
//     addr=0, addr_ch=0, addr_wrap=0. Reset mid-transfer drops any pending output.
//   Handshake: req_ready = !addr_valid || addr_ready (combinational). Accepted request -> result
//     registered, addr_valid=1 on next cycle (latency 1). Output held stable while
//     addr_valid && !addr_ready.
//   nxt = modify(ptr): sum = ptr + sign_extend(step), computed at ADDR_W+1 bits.
//     linear: nxt = sum mod 2^ADDR_W; wrap = carry/borrow out of ADDR_W.
//     circular, len!=0: if sum >= base+len then nxt = sum-len, wrap=1;
//       elif sum < base then nxt = sum+len, wrap=1; else nxt = sum, wrap=0.
//       Only a single correction is applied; software guarantees |step| <= len and base+len <= 2^ADDR_W.
//     circular, len==0: nxt = base, wrap=0.
//   Ops: peek    addr=ptr, ptr unchanged, wrap=0.
//        post    addr=ptr, ptr<=nxt, wrap=wrap(nxt).
//        pre     addr=nxt, ptr<=nxt, wrap=wrap(nxt).
//        reload  addr=base, ptr<=base, wrap=0.
//   Pointer updates happen only on accepted requests; they are not applied while the output stalls.
//   Config writes are always accepted (no ready). A write takes effect at the clk edge, so a
//     request in the same cycle sees the old values.
//   Same cycle, same channel: cfg base write and a ptr-updating request -> the request's addr
//     uses the old values; ptr<=new base (cfg wins). A cfg write to a different channel is independent.
//   Back-to-back: a request on the channel updated last cycle sees the updated ptr (no hazard bubble).
//   Request for a ch >= NCH is impossible by width (NCH power of 2).
// TESTING
//   1 Reset: assert s_reset 2 cycles mid-stall -> addr_valid=0, ch0 post-op returns addr=0, next 1.
//   2 Linear: base=0xFFFE, step=+1, 3x post on ch1 -> addr 0xFFFE,0xFFFF,0x0000; wrap=0,1,0.
//   3 Circular: ch2 base=0x100 len=4 step=+3, 4x post -> 0x100,0x103,0x102,0x101; wrap 0,1,1,1;
//     with step=-1, pre -> 0x103 wrap=1.
//   4 Backpressure: addr_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, addr held, ptr
//     advances exactly once per accepted request.
//   5 Collision: cfg base=0x200 on ch3 with post on ch3 (ptr=0x50) -> addr=0x50, next peek=0x200.
//   6 Interleave: ch0/ch1 alternating post every cycle, addr_ready=1 -> independent sequences,
//     addr_ch matches, throughput 1/cycle.

Source files
------------

// File: rtl/address_generation_unit_mc.sv
// ---------------------------------------------------------------------------
// address_generation_unit_mc
//
// Multi-channel address generation unit. Holds NCH independent pointer
// channels, each with its own base, length, signed step and mode (linear or
// circular). Serves one address request per cycle through a registered
// output stage with valid/ready backpressure.
//
// Ports
//   i_clk          system clock, rising edge
//   i_s_reset      synchronous active-high reset
//   i_cfg_we       configuration write strobe (always accepted)
//   i_cfg_ch       channel being configured
//   i_cfg_sel      0=base (also loads ptr) 1=length 2=step 3=mode
//   i_cfg_wdata    write data (step uses [STEP_W-1:0], mode uses [0])
//   i_req_valid    address request
//   o_req_ready    request accepted when i_req_valid && o_req_ready
//   i_req_ch       channel addressed by the request
//   i_req_op       00 peek, 01 post-modify, 10 pre-modify, 11 reload
//   o_addr_valid   output address valid
//   i_addr_ready   downstream accepts the output
//   o_addr         generated address
//   o_addr_ch      channel that produced o_addr
//   o_addr_wrap    pointer update wrapped (circular or 2^ADDR_W overflow)
// ---------------------------------------------------------------------------
module address_generation_unit_mc #(
    parameter int ADDR_W = 16,
    parameter int NCH    = 4,
    parameter int STEP_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_s_reset,
    input  logic                   i_cfg_we,
    input  logic [$clog2(NCH)-1:0] i_cfg_ch,
    input  logic [1:0]             i_cfg_sel,
    input  logic [ADDR_W-1:0]      i_cfg_wdata,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [$clog2(NCH)-1:0] i_req_ch,
    input  logic [1:0]             i_req_op,
    output logic                   o_addr_valid,
    input  logic                   i_addr_ready,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [$clog2(NCH)-1:0] o_addr_ch,
    output logic                   o_addr_wrap
);

    localparam int CH_W = $clog2(NCH);
    // Sum width: one carry bit plus one sign bit so a borrow below zero is
    // distinguishable from a large positive sum in circular mode.
    localparam int SW   = ADDR_W + 2;

    localparam logic [1:0] OP_PEEK   = 2'b00;
    localparam logic [1:0] OP_POST   = 2'b01;
    localparam logic [1:0] OP_PRE    = 2'b10;
    localparam logic [1:0] OP_RELOAD = 2'b11;

    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_LEN  = 2'd1;
    localparam logic [1:0] SEL_STEP = 2'd2;
    localparam logic [1:0] SEL_MODE = 2'd3;

    // Per-channel state
    logic [ADDR_W-1:0] r_ptr  [NCH];
    logic [ADDR_W-1:0] r_base [NCH];
    logic [ADDR_W-1:0] r_len  [NCH];
    logic [STEP_W-1:0] r_step [NCH];
    logic              r_mode [NCH];

    // Output stage
    logic              r_addr_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [CH_W-1:0]   r_addr_ch;
    logic              r_addr_wrap;

    // Selected channel view
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_len;
    logic [STEP_W-1:0] w_step;
    logic              w_mode;

    logic [SW-1:0]     w_step_ext;
    logic [SW-1:0]     w_sum;
    logic              w_sum_neg;
    logic [ADDR_W:0]   w_sum_lo;
    logic [ADDR_W:0]   w_lim;
    logic [ADDR_W-1:0] w_sum_trunc;

    logic [ADDR_W-1:0] w_nxt;
    logic              w_nxt_wrap;

    logic [ADDR_W-1:0] w_res_addr;
    logic              w_res_wrap;
    logic              w_upd;
    logic [ADDR_W-1:0] w_upd_val;

    logic              w_accept;

    assign o_req_ready = !r_addr_valid || i_addr_ready;
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_ptr  = r_ptr[i_req_ch];
    assign w_base = r_base[i_req_ch];
    assign w_len  = r_len[i_req_ch];
    assign w_step = r_step[i_req_ch];
    assign w_mode = r_mode[i_req_ch];

    assign w_step_ext  = {{(SW-STEP_W){w_step[STEP_W-1]}}, w_step};
    assign w_sum       = {2'b00, w_ptr} + w_step_ext;
    assign w_sum_neg   = w_sum[SW-1];
    assign w_sum_lo    = w_sum[ADDR_W:0];
    assign w_sum_trunc = w_sum[ADDR_W-1:0];
    assign w_lim       = {1'b0, w_base} + {1'b0, w_len};

    // Next pointer value. In linear mode bit ADDR_W of the sum is set both on
    // a carry (positive step) and on a borrow (negative step), so it serves
    // directly as the wrap flag.
    always_comb begin
        w_nxt      = w_sum_trunc;
        w_nxt_wrap = w_sum[ADDR_W];
        if (w_mode) begin
            if (w_len == '0) begin
                w_nxt      = w_base;
                w_nxt_wrap = 1'b0;
            end else if (!w_sum_neg && (w_sum_lo >= w_lim)) begin
                w_nxt      = w_sum_trunc - w_len;
                w_nxt_wrap = 1'b1;
            end else if (w_sum_neg || (w_sum_lo < {1'b0, w_base})) begin
                w_nxt      = w_sum_trunc + w_len;
                w_nxt_wrap = 1'b1;
            end else begin
                w_nxt      = w_sum_trunc;
                w_nxt_wrap = 1'b0;
            end
        end
    end

    // Result of the requested operation
    always_comb begin
        w_res_addr = w_ptr;
        w_res_wrap = 1'b0;
        w_upd      = 1'b0;
        w_upd_val  = w_ptr;
        case (i_req_op)
            OP_PEEK: begin
                w_res_addr = w_ptr;
                w_res_wrap = 1'b0;
            end
            OP_POST: begin
                w_res_addr = w_ptr;
                w_res_wrap = w_nxt_wrap;
                w_upd      = 1'b1;
                w_upd_val  = w_nxt;
            end
            OP_PRE: begin
                w_res_addr = w_nxt;
                w_res_wrap = w_nxt_wrap;
                w_upd      = 1'b1;
                w_upd_val  = w_nxt;
            end
            OP_RELOAD: begin
                w_res_addr = w_base;
                w_res_wrap = 1'b0;
                w_upd      = 1'b1;
                w_upd_val  = w_base;
            end
            default: begin
                w_res_addr = w_ptr;
                w_res_wrap = 1'b0;
            end
        endcase
    end

    // Channel registers. The configuration write is evaluated after the
    // request update so a base write to the same channel overrides the
    // pointer update from a request in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_s_reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_ptr[i]  <= '0;
                r_base[i] <= '0;
                r_len[i]  <= '0;
                r_step[i] <= STEP_W'(1);
                r_mode[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_accept && w_upd && (i_req_ch == CH_W'(i))) begin
                    r_ptr[i] <= w_upd_val;
                end
                if (i_cfg_we && (i_cfg_ch == CH_W'(i))) begin
                    case (i_cfg_sel)
                        SEL_BASE: begin
                            r_base[i] <= i_cfg_wdata;
                            r_ptr[i]  <= i_cfg_wdata;
                        end
                        SEL_LEN:  r_len[i]  <= i_cfg_wdata;
                        SEL_STEP: r_step[i] <= i_cfg_wdata[STEP_W-1:0];
                        SEL_MODE: r_mode[i] <= i_cfg_wdata[0];
                        default:  r_len[i]  <= r_len[i];
                    endcase
                end
            end
        end
    end

    // Registered output stage; holds while valid and not accepted downstream.
    always_ff @(posedge i_clk) begin
        if (i_s_reset) begin
            r_addr_valid <= 1'b0;
            r_addr       <= '0;
            r_addr_ch    <= '0;
            r_addr_wrap  <= 1'b0;
        end else if (o_req_ready) begin
            r_addr_valid <= i_req_valid;
            if (i_req_valid) begin
                r_addr      <= w_res_addr;
                r_addr_ch   <= i_req_ch;
                r_addr_wrap <= w_res_wrap;
            end
        end
    end

    assign o_addr_valid = r_addr_valid;
    assign o_addr       = r_addr;
    assign o_addr_ch    = r_addr_ch;
    assign o_addr_wrap  = r_addr_wrap;

endmodule

// File: tb/tb_address_generation_unit_mc.sv
module tb_address_generation_unit_mc;

    logic        i_clk;
    logic        i_s_reset;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_ch;
    logic [1:0]  i_cfg_sel;
    logic [15:0] i_cfg_wdata;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_req_ch;
    logic [1:0]  i_req_op;
    logic        o_addr_valid;
    logic        i_addr_ready;
    logic [15:0] o_addr;
    logic [1:0]  o_addr_ch;
    logic        o_addr_wrap;

    int n_vec = 0;
    int n_err = 0;

    address_generation_unit_mc #(.ADDR_W(16), .NCH(4), .STEP_W(8)) dut (
        .i_clk        (i_clk),
        .i_s_reset    (i_s_reset),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_ch     (i_cfg_ch),
        .i_cfg_sel    (i_cfg_sel),
        .i_cfg_wdata  (i_cfg_wdata),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_ch     (i_req_ch),
        .i_req_op     (i_req_op),
        .o_addr_valid (o_addr_valid),
        .i_addr_ready (i_addr_ready),
        .o_addr       (o_addr),
        .o_addr_ch    (o_addr_ch),
        .o_addr_wrap  (o_addr_wrap)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    // Stimulus helpers: called at a negedge, return at the following negedge.
    task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
        i_cfg_we    = 1'b1;
        i_cfg_ch    = ch;
        i_cfg_sel   = sel;
        i_cfg_wdata = data;
        @(negedge i_clk);
        i_cfg_we    = 1'b0;
    endtask

    task automatic req1(input logic [1:0] ch, input logic [1:0] op);
        i_req_valid = 1'b1;
        i_req_ch    = ch;
        i_req_op    = op;
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (o_addr_valid !== 1'b0) begin n_err++; $display("FAIL por_valid: got %b expected 0", o_addr_valid); end
        n_vec++; if (o_addr !== 16'h0000) begin n_err++; $display("FAIL por_addr: got %h expected 0000", o_addr); end
        n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL por_ready: got %b expected 1", o_req_ready); end
        cfg(2'd0, 2'd0, 16'h0010);
        i_addr_ready = 1'b0;
        req1(2'd0, 2'b01);
        n_vec++; if (o_addr_valid !== 1'b1 || o_addr !== 16'h0010) begin n_err++; $display("FAIL rst_pre_stall: got v=%b a=%h expected v=1 a=0010", o_addr_valid, o_addr); end
        @(negedge i_clk);
        n_vec++; if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_stall_ready: got %b expected 0", o_req_ready); end
        i_s_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_s_reset = 1'b0;
        n_vec++; if (o_addr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", o_addr_valid); end
        n_vec++; if (o_addr !== 16'h0 || o_addr_ch !== 2'd0 || o_addr_wrap !== 1'b0) begin n_err++; $display("FAIL rst_outs: got a=%h ch=%0d w=%b expected 0,0,0", o_addr, o_addr_ch, o_addr_wrap); end
        i_addr_ready = 1'b1;
        req1(2'd0, 2'b01);
        n_vec++; if (o_addr_valid !== 1'b1 || o_addr !== 16'h0000) begin n_err++; $display("FAIL rst_post0: got v=%b a=%h expected v=1 a=0000", o_addr_valid, o_addr); end
        req1(2'd0, 2'b01);
        n_vec++; if (o_addr !== 16'h0001) begin n_err++; $display("FAIL rst_post1: got %h expected 0001", o_addr); end
        @(negedge i_clk);
    endtask

    task automatic test_linear();
        logic [15:0] ea [3];
        logic        ew [3];
        ea = '{16'hFFFE, 16'hFFFF, 16'h0000};
        ew = '{1'b0, 1'b1, 1'b0};
        cfg(2'd1, 2'd0, 16'hFFFE);
        i_req_valid = 1'b1; i_req_ch = 2'd1; i_req_op = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            n_vec++; if (o_addr_valid !== 1'b1 || o_addr !== ea[i] || o_addr_wrap !== ew[i] || o_addr_ch !== 2'd1)
                begin n_err++; $display("FAIL lin_post%0d: got v=%b a=%h w=%b ch=%0d expected v=1 a=%h w=%b ch=1", i, o_addr_valid, o_addr, o_addr_wrap, o_addr_ch, ea[i], ew[i]); end
        end
        i_req_valid = 1'b0;
        cfg(2'd1, 2'd2, 16'h00FF);
        cfg(2'd1, 2'd0, 16'h0001);
        req1(2'd1, 2'b01);
        n_vec++; if (o_addr !== 16'h0001 || o_addr_wrap !== 1'b0) begin n_err++; $display("FAIL lin_neg0: got a=%h w=%b expected 0001 0", o_addr, o_addr_wrap); end
        req1(2'd1, 2'b01);
        n_vec++; if (o_addr !== 16'h0000 || o_addr_wrap !== 1'b1) begin n_err++; $display("FAIL lin_borrow: got a=%h w=%b expected 0000 1", o_addr, o_addr_wrap); end
        req1(2'd1, 2'b00);
        n_vec++; if (o_addr !== 16'hFFFF || o_addr_wrap !== 1'b0) begin n_err++; $display("FAIL lin_peek: got a=%h w=%b expected ffff 0", o_addr, o_addr_wrap); end
        @(negedge i_clk);
    endtask

    task automatic test_circular();
        logic [15:0] ea [4];
        logic        ew [4];
        ea = '{16'h0100, 16'h0103, 16'h0102, 16'h0101};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1};
        cfg(2'd2, 2'd0, 16'h0100);
        cfg(2'd2, 2'd1, 16'h0004);
        cfg(2'd2, 2'd2, 16'h0003);
        cfg(2'd2, 2'd3, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            req1(2'd2, 2'b01);
            n_vec++; if (o_addr !== ea[i] || o_addr_wrap !== ew[i]) begin n_err++; $display("FAIL circ_post%0d: got a=%h w=%b expected a=%h w=%b", i, o_addr, o_addr_wrap, ea[i], ew[i]); end
        end
        cfg(2'd2, 2'd2, 16'h00FF);
        req1(2'd2, 2'b10);
        n_vec++; if (o_addr !== 16'h0103 || o_addr_wrap !== 1'b1) begin n_err++; $display("FAIL circ_pre_neg: got a=%h w=%b expected 0103 1", o_addr, o_addr_wrap); end
        req1(2'd2, 2'b11);
        n_vec++; if (o_addr !== 16'h0100 || o_addr_wrap !== 1'b0) begin n_err++; $display("FAIL circ_reload: got a=%h w=%b expected 0100 0", o_addr, o_addr_wrap); end
        req1(2'd2, 2'b01);
        n_vec++; if (o_addr !== 16'h0100 || o_addr_wrap !== 1'b1) begin n_err++; $display("FAIL circ_post_neg: got a=%h w=%b expected 0100 1", o_addr, o_addr_wrap); end
        cfg(2'd2, 2'd1, 16'h0000);
        req1(2'd2, 2'b10);
        n_vec++; if (o_addr !== 16'h0100 || o_addr_wrap !== 1'b0) begin n_err++; $display("FAIL circ_len0: got a=%h w=%b expected 0100 0", o_addr, o_addr_wrap); end
        @(negedge i_clk);
    endtask

    task automatic test_backpressure();
        cfg(2'd0, 2'd0, 16'h0020);
        cfg(2'd0, 2'd2, 16'h0002);
        i_addr_ready = 1'b0;
        i_req_valid = 1'b1; i_req_ch = 2'd0; i_req_op = 2'b01;
        @(negedge i_clk);
        n_vec++; if (o_addr_valid !== 1'b1 || o_addr !== 16'h0020) begin n_err++; $display("FAIL bp_first: got v=%b a=%h expected v=1 a=0020", o_addr_valid, o_addr); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (o_req_ready !== 1'b0 || o_addr_valid !== 1'b1 || o_addr !== 16'h0020)
                begin n_err++; $display("FAIL bp_hold%0d: got rdy=%b v=%b a=%h expected rdy=0 v=1 a=0020", i, o_req_ready, o_addr_valid, o_addr); end
            @(negedge i_clk);
        end
        i_addr_ready = 1'b1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        n_vec++; if (o_addr_valid !== 1'b1 || o_addr !== 16'h0022) begin n_err++; $display("FAIL bp_second: got v=%b a=%h expected v=1 a=0022", o_addr_valid, o_addr); end
        @(negedge i_clk);
        n_vec++; if (o_addr_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got v=%b expected 0", o_addr_valid); end
        req1(2'd0, 2'b00);
        n_vec++; if (o_addr !== 16'h0024) begin n_err++; $display("FAIL bp_ptr: got %h expected 0024", o_addr); end
        @(negedge i_clk);
    endtask

    task automatic test_collision();
        cfg(2'd3, 2'd0, 16'h0050);
        i_cfg_we = 1'b1; i_cfg_ch = 2'd3; i_cfg_sel = 2'd0; i_cfg_wdata = 16'h0200;
        i_req_valid = 1'b1; i_req_ch = 2'd3; i_req_op = 2'b01;
        @(negedge i_clk);
        i_cfg_we = 1'b0; i_req_valid = 1'b0;
        n_vec++; if (o_addr !== 16'h0050 || o_addr_ch !== 2'd3) begin n_err++; $display("FAIL col_addr: got a=%h ch=%0d expected 0050 3", o_addr, o_addr_ch); end
        req1(2'd3, 2'b00);
        n_vec++; if (o_addr !== 16'h0200) begin n_err++; $display("FAIL col_peek: got %h expected 0200", o_addr); end
        i_cfg_we = 1'b1; i_cfg_ch = 2'd2; i_cfg_sel = 2'd0; i_cfg_wdata = 16'h0300;
        i_req_valid = 1'b1; i_req_ch = 2'd3; i_req_op = 2'b01;
        @(negedge i_clk);
        i_cfg_we = 1'b0; i_req_valid = 1'b0;
        n_vec++; if (o_addr !== 16'h0200) begin n_err++; $display("FAIL col_other_addr: got %h expected 0200", o_addr); end
        req1(2'd3, 2'b00);
        n_vec++; if (o_addr !== 16'h0201) begin n_err++; $display("FAIL col_other_ptr: got %h expected 0201", o_addr); end
        req1(2'd2, 2'b00);
        n_vec++; if (o_addr !== 16'h0300) begin n_err++; $display("FAIL col_other_base: got %h expected 0300", o_addr); end
        @(negedge i_clk);
    endtask

    task automatic test_interleave();
        logic [15:0] ea [6];
        ea = '{16'h1000, 16'h2000, 16'h1004, 16'h1FFE, 16'h1008, 16'h1FFC};
        cfg(2'd0, 2'd0, 16'h1000);
        cfg(2'd0, 2'd2, 16'h0004);
        cfg(2'd1, 2'd0, 16'h2000);
        cfg(2'd1, 2'd2, 16'h00FE);
        i_req_valid = 1'b1; i_req_op = 2'b01;
        for (int i = 0; i < 6; i++) begin
            i_req_ch = 2'(i % 2);
            @(negedge i_clk);
            n_vec++; if (o_addr_valid !== 1'b1 || o_addr_ch !== 2'(i % 2) || o_addr !== ea[i] || o_req_ready !== 1'b1)
                begin n_err++; $display("FAIL ilv%0d: got v=%b ch=%0d a=%h rdy=%b expected v=1 ch=%0d a=%h rdy=1", i, o_addr_valid, o_addr_ch, o_addr, o_req_ready, i % 2, ea[i]); end
        end
        i_req_valid = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        i_s_reset    = 1'b1;
        i_cfg_we     = 1'b0;
        i_cfg_ch     = 2'd0;
        i_cfg_sel    = 2'd0;
        i_cfg_wdata  = 16'h0;
        i_req_valid  = 1'b0;
        i_req_ch     = 2'd0;
        i_req_op     = 2'b00;
        i_addr_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        i_s_reset = 1'b0;
        test_reset();
        test_linear();
        test_circular();
        test_backpressure();
        test_collision();
        test_interleave();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
